muldiv_seq: RTL and testbench

// Iterative multiply/divide sequencer with the architectural HI/LO registers for the pipelined MIPS core.
// - Launched from the EX stage by the decoded mult/multu/div/divu op.
// - Runs a shift-add multiply or restoring divide over WIDTH cycles, then writes HI/LO.
// - Raises stallD so that younger HI/LO users wait in Decode until the result is committed.
// - Younger HI/LO users are mfhi/mflo/mthi/mtlo and further mul/div ops.

---
 rtl/muldiv_seq.sv | 98 +++++++++
 tb/tb_muldiv_seq.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative shift-add multiply / restoring divide with the HI/LO registers
// and the Decode stall that orders younger HI/LO users behind the in-flight op.
module muldiv_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             startE,
   input  logic [1:0]       opE,
   input  logic [WIDTH-1:0] srcaE,
   input  logic [WIDTH-1:0] srcbE,
   input  logic             hiloD,
   input  logic             mthiW,
   input  logic             mtloW,
   input  logic [WIDTH-1:0] wdW,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             stallD
);
   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
   localparam int CW = $clog2(WIDTH);
   state_t           state;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] dsr, up, low;
   logic             isdiv, neg, negr;
   logic             sa, sb;
   logic [WIDTH-1:0] ma, mb, fix_hi, fix_lo;
   logic [WIDTH:0]   madd, shr, diff;
   logic [2*WIDTH-1:0] prod;
   // multiplication commutes, so both ops load |a| into low and |b| into dsr
   always_comb begin
      sa     = ~opE[0] & srcaE[WIDTH-1];
      sb     = ~opE[0] & srcbE[WIDTH-1];
      ma     = sa ? -srcaE : srcaE;
      mb     = sb ? -srcbE : srcbE;
      madd   = {1'b0, up} + {1'b0, low[0] ? dsr : {WIDTH{1'b0}}};
      shr    = {up, low[WIDTH-1]};
      diff   = shr - {1'b0, dsr};
      prod   = neg ? -{up, low} : {up, low};
      fix_hi = isdiv ? (negr ? -up : up) : prod[2*WIDTH-1:WIDTH];
      fix_lo = isdiv ? (neg ? -low : low) : prod[WIDTH-1:0];
      stallD = hiloD & (busy | startE);
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         busy  <= 1'b0;
         count <= '0;
         dsr   <= '0;
         up    <= '0;
         low   <= '0;
         isdiv <= 1'b0;
         neg   <= 1'b0;
         negr  <= 1'b0;
         hi    <= '0;
         lo    <= '0;
      end else begin
         case (state)
            IDLE: if (startE) begin
               state <= RUN;
               busy  <= 1'b1;
               count <= CW'(WIDTH - 1);
               dsr   <= mb;
               low   <= ma;
               up    <= '0;
               isdiv <= opE[1];
               neg   <= sa ^ sb;
               negr  <= sa;
            end
            RUN: begin
               if (isdiv) begin
                  up  <= diff[WIDTH] ? shr[WIDTH-1:0] : diff[WIDTH-1:0];
                  low <= {low[WIDTH-2:0], ~diff[WIDTH]};
               end else begin
                  up  <= madd[WIDTH:1];
                  low <= {madd[0], low[WIDTH-1:1]};
               end
               if (count == '0) state <= FIX;
               else count <= count - 1'b1;
            end
            FIX: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
         // the committing op wins over a same-cycle mthi/mtlo
         if (state == FIX) begin
            hi <= fix_hi;
            lo <= fix_lo;
         end else begin
            if (mthiW) hi <= wdW;
            if (mtloW) lo <= wdW;
         end
      end
   end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: randomized and directed checks of muldiv_seq against an arithmetic model.
module tb_muldiv_seq;
   logic        clk, reset, startE, hiloD, mthiW, mtloW, busy, stallD;
   logic [1:0]  opE;
   logic [31:0] srcaE, srcbE, wdW, hi, lo;
   int checks = 0, passed = 0;

   muldiv_seq #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .startE(startE), .opE(opE), .srcaE(srcaE), .srcbE(srcbE),
      .hiloD(hiloD), .mthiW(mthiW), .mtloW(mtloW), .wdW(wdW),
      .hi(hi), .lo(lo), .busy(busy), .stallD(stallD)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   always @(posedge clk) if (startE && busy) begin
      checks++;
      $display("FAIL start_while_busy: startE=1 busy=1, required startE=0 while busy");
   end

   function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      longint unsigned ua, ub;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      case (op)
         2'd0: return sa * sb;
         2'd1: return ua * ub;
         2'd2: begin
            if (b == 0) return {a, a[31] ? 32'd1 : 32'hFFFFFFFF};
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
         end
         default: begin
            if (b == 0) return {a, 32'hFFFFFFFF};
            return {32'(ua % ub), 32'(ua / ub)};
         end
      endcase
   endfunction

   task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, output int bc);
      startE = 1; opE = op; srcaE = a; srcbE = b;
      @(posedge clk); #1;
      startE = 0;
      bc = 0;
      while (busy && bc < 100) begin
         bc++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset;
      reset = 1;
      repeat (2) @(posedge clk);
      #1 reset = 0;
      checks++; if (hi !== 32'h0) $display("FAIL reset_hi: got %h want 0", hi); else passed++;
      checks++; if (lo !== 32'h0) $display("FAIL reset_lo: got %h want 0", lo); else passed++;
      checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
      checks++; if (stallD !== 1'b0) $display("FAIL reset_stall: got %b want 0", stallD); else passed++;
   endtask

   task automatic test_directed;
      logic [1:0]  op [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2};
      logic [31:0] a  [6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'd100, 32'd5, 32'h80000000};
      logic [31:0] b  [6] = '{32'h2, 32'h2, 32'h2, 32'd7, 32'd0, 32'hFFFFFFFF};
      logic [31:0] eh [6] = '{32'hFFFFFFFF, 32'h1, 32'hFFFFFFFF, 32'd2, 32'd5, 32'h0};
      logic [31:0] el [6] = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd14, 32'hFFFFFFFF, 32'h80000000};
      int bc;
      for (int i = 0; i < 6; i++) begin
         launch(op[i], a[i], b[i], bc);
         checks++; if (bc !== 33) $display("FAIL dir%0d_busy_cycles: got %0d want 33", i, bc); else passed++;
         checks++; if (hi !== eh[i]) $display("FAIL dir%0d_hi: got %h want %h", i, hi, eh[i]); else passed++;
         checks++; if (lo !== el[i]) $display("FAIL dir%0d_lo: got %h want %h", i, lo, el[i]); else passed++;
      end
   endtask

   task automatic test_random;
      logic [31:0] edges [6] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h2};
      logic [31:0] a, b;
      logic [1:0]  op;
      logic [63:0] exp;
      int bc;
      for (int i = 0; i < 48; i++) begin
         op = 2'($urandom_range(0, 3));
         a = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
         b = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] :
             ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom;
         exp = model(op, a, b);
         launch(op, a, b, bc);
         checks++;
         if ({hi, lo} !== exp || bc !== 33)
            $display("FAIL rand%0d op=%0d a=%h b=%h: got hi:lo=%h cycles=%0d want %h cycles=33", i, op, a, b, {hi, lo}, bc, exp);
         else passed++;
      end
   endtask

   task automatic test_hazard;
      int n = 0, bad = 0;
      hiloD = 1;
      startE = 1; opE = 2'd3; srcaE = 32'd100; srcbE = 32'd7;
      #1;
      checks++; if (stallD !== 1'b1) $display("FAIL stall_on_start: got %b want 1", stallD); else passed++;
      @(posedge clk); #1;
      startE = 0;
      while (busy && n < 100) begin
         n++;
         if (stallD !== 1'b1) bad++;
         @(posedge clk); #1;
      end
      checks++; if (bad !== 0 || n !== 33) $display("FAIL stall_while_busy: %0d unstalled of %0d busy cycles, want 0 of 33", bad, n); else passed++;
      checks++; if (stallD !== 1'b0) $display("FAIL stall_after_fix: got %b want 0", stallD); else passed++;
      hiloD = 0;
      launch(2'd1, 32'd3, 32'd4, n);
      hiloD = 0;
      startE = 1; opE = 2'd0; srcaE = 32'd3; srcbE = 32'd4;
      @(posedge clk); #1;
      startE = 0;
      checks++; if (stallD !== 1'b0 || busy !== 1'b1) $display("FAIL no_stall_without_hilo: stallD=%b busy=%b want 0 1", stallD, busy); else passed++;
      while (busy && n < 200) begin n++; @(posedge clk); #1; end
   endtask

   task automatic test_mt;
      int bc = 0;
      mthiW = 1; wdW = 32'h1234;
      @(posedge clk); #1 mthiW = 0;
      checks++; if (hi !== 32'h1234) $display("FAIL mthi_idle: got %h want 00001234", hi); else passed++;
      mtloW = 1; wdW = 32'h5678;
      @(posedge clk); #1 mtloW = 0;
      checks++; if (lo !== 32'h5678) $display("FAIL mtlo_idle: got %h want 00005678", lo); else passed++;
      startE = 1; opE = 2'd1; srcaE = 32'd6; srcbE = 32'd7;
      @(posedge clk); #1 startE = 0;
      repeat (3) @(posedge clk);
      #1 mtloW = 1; wdW = 32'hABCD;
      @(posedge clk); #1 mtloW = 0;
      checks++; if (lo !== 32'hABCD || busy !== 1'b1) $display("FAIL mtlo_busy: lo=%h busy=%b want 0000abcd 1", lo, busy); else passed++;
      while (busy && bc < 100) begin
         bc++;
         mthiW = 1; wdW = 32'hDEAD;
         @(posedge clk); #1;
      end
      mthiW = 0;
      checks++; if (hi !== 32'h0 || lo !== 32'd42) $display("FAIL fix_beats_mt: hi=%h lo=%h want 00000000 0000002a", hi, lo); else passed++;
   endtask

   task automatic test_abort;
      int bc;
      mthiW = 1; mtloW = 1; wdW = 32'h55AA;
      @(posedge clk); #1 mthiW = 0; mtloW = 0;
      startE = 1; opE = 2'd0; srcaE = 32'd7; srcbE = 32'd9;
      @(posedge clk); #1 startE = 0;
      repeat (9) @(posedge clk);
      #1 reset = 1; hiloD = 1;
      @(posedge clk); #1 reset = 0;
      checks++; if (busy !== 1'b0 || stallD !== 1'b0) $display("FAIL abort_idle: busy=%b stallD=%b want 0 0", busy, stallD); else passed++;
      checks++; if (hi !== 32'h0 || lo !== 32'h0) $display("FAIL abort_hilo: hi=%h lo=%h want 0 0", hi, lo); else passed++;
      hiloD = 0;
      repeat (40) @(posedge clk);
      #1;
      checks++; if (hi !== 32'h0 || lo !== 32'h0) $display("FAIL abort_no_late_write: hi=%h lo=%h want 0 0", hi, lo); else passed++;
      launch(2'd0, 32'hFFFFFFFF, 32'h2, bc);
      checks++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFE || bc !== 33)
         $display("FAIL mult_after_abort: hi=%h lo=%h cycles=%0d want ffffffff fffffffe 33", hi, lo, bc);
      else passed++;
   endtask

   initial begin
      reset = 1; startE = 0; opE = 0; srcaE = 0; srcbE = 0;
      hiloD = 0; mthiW = 0; mtloW = 0; wdW = 0;
      test_reset;
      test_directed;
      test_random;
      test_hazard;
      test_mt;
      test_abort;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
